// File: rtl/rect_copy_controller.sv
`default_nettype none
// ============================================================================
// Module   : rect_copy_controller
// Purpose  : Streams RECT_COUNT*RECT_WORDS 16-bit words from data memory into
//            the GPU rectangle registers, one word per clock. A copy runs only
//            while the copy window is open. Closing the window mid-copy ends
//            the copy and sets the sticky aborted flag.
// Ports    : clk         - single clock, rising edge
//            reset_n     - asynchronous active-low reset
//            copy_start  - one-cycle start pulse (honoured only in IDLE with copy=1)
//            copy        - copy-window flag; memory is owned while high
//            mem_addr    - data-memory read address (16-bit, wraps)
//            mem_re      - data-memory read enable
//            mem_rdata   - read data, valid one cycle after mem_re
//            rect_we     - rectangle-register write strobe
//            rect_idx    - rectangle index of the current write
//            rect_field  - field index of the current write
//            rect_data   - write data (mem_rdata of the current cycle)
//            busy        - copy in progress
//            done        - one-cycle pulse on full completion
//            aborted     - sticky; set when a copy is cut short
// Revision : 1.0 - initial release
// ============================================================================
module rect_copy_controller #(
  parameter int          RECT_COUNT = 64,
  parameter int          RECT_WORDS = 6,
  parameter logic [15:0] MEM_BASE   = 16'h0000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          copy_start,
  input  logic                          copy,
  output logic [15:0]                   mem_addr,
  output logic                          mem_re,
  input  logic [15:0]                   mem_rdata,
  output logic                          rect_we,
  output logic [$clog2(RECT_COUNT)-1:0] rect_idx,
  output logic [$clog2(RECT_WORDS)-1:0] rect_field,
  output logic [15:0]                   rect_data,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted
);

  localparam int c_N  = RECT_COUNT * RECT_WORDS;
  localparam int c_IW = $clog2(RECT_COUNT);
  localparam int c_FW = $clog2(RECT_WORDS);
  localparam int c_CW = $clog2(c_N + 1);

  localparam logic [c_FW-1:0] c_FIELD_LAST = c_FW'(RECT_WORDS - 1);
  localparam logic [c_CW-1:0] c_LAST_READ  = c_CW'(c_N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [15:0]       r_addr;
  logic [c_CW-1:0]   r_rcnt;   // index k of the read issued this cycle
  logic [c_IW-1:0]   r_idx;
  logic [c_FW-1:0]   r_field;
  logic              r_re;
  logic              r_we;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;

  // Strobes are qualified by the window flag so that no memory access or
  // register write is ever presented in a cycle where the memory is not ours,
  // including the cycle in which the window closes.
  assign mem_re     = r_re & copy;
  assign rect_we    = r_we & copy;
  assign mem_addr   = r_addr;
  assign rect_idx   = r_idx;
  assign rect_field = r_field;
  assign rect_data  = mem_rdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign aborted    = r_aborted;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_addr    <= 16'h0000;
      r_rcnt    <= '0;
      r_idx     <= '0;
      r_field   <= '0;
      r_re      <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (copy_start && copy) begin
            r_state   <= S_READ;
            r_aborted <= 1'b0;
            r_busy    <= 1'b1;
            r_re      <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= MEM_BASE;
            r_rcnt    <= '0;
            r_idx     <= '0;
            r_field   <= '0;
          end
        end

        S_READ: begin
          if (!copy) begin
            r_state   <= S_IDLE;
            r_aborted <= 1'b1;
            r_busy    <= 1'b0;
            r_re      <= 1'b0;
            r_we      <= 1'b0;
          end else begin
            // Every read is followed by its write one cycle later; the
            // write coordinates advance only once a write has been issued.
            r_we <= 1'b1;
            if (r_we) begin
              if (r_field == c_FIELD_LAST) begin
                r_field <= '0;
                r_idx   <= r_idx + c_IW'(1);
              end else begin
                r_field <= r_field + c_FW'(1);
              end
            end
            if (r_rcnt == c_LAST_READ) begin
              r_re    <= 1'b0;
              r_state <= S_DRAIN;
            end else begin
              r_rcnt <= r_rcnt + c_CW'(1);
              r_addr <= r_addr + 16'd1;
            end
          end
        end

        S_DRAIN: begin
          if (!copy) begin
            r_state   <= S_IDLE;
            r_aborted <= 1'b1;
            r_busy    <= 1'b0;
            r_re      <= 1'b0;
            r_we      <= 1'b0;
          end else begin
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rect_copy_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_copy_controller
// Purpose  : Scoreboard bench for rect_copy_controller. Two small instances
//            (base 0x0100 and base 0xFFFE) share one stimulus stream; a third
//            instance with default parameters runs one full-size copy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rect_copy_controller;

  localparam int RC = 2;
  localparam int RW = 3;
  localparam int N  = RC * RW;
  localparam logic [15:0] BASE_A = 16'h0100;
  localparam logic [15:0] BASE_W = 16'hFFFE;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  idx;
    logic [7:0]  fld;
    logic [15:0] data;
  } wr_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] addr;
  } rd_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic copy_start = 1'b0;
  logic copy = 1'b0;
  logic d_start = 1'b0;
  logic d_copy = 1'b0;

  logic [15:0] mem [0:65535];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  // instance A (base 0x0100)
  logic [15:0] a_addr, a_rdata, a_data;
  logic        a_re, a_we, a_busy, a_done, a_ab;
  logic [0:0]  a_idx;
  logic [1:0]  a_fld;
  // instance W (base 0xFFFE)
  logic [15:0] w_addr, w_rdata, w_data;
  logic        w_re, w_we, w_busy, w_done, w_ab;
  logic [0:0]  w_idx;
  logic [1:0]  w_fld;
  // instance D (default parameters)
  logic [15:0] d_addr, d_rdata, d_data;
  logic        d_re, d_we, d_busy, d_done, d_ab;
  logic [5:0]  d_idx;
  logic [2:0]  d_fld;

  wr_t q_wa[$], q_ww[$];
  rd_t q_ra[$], q_rw[$];
  int  q_done[$];

  int def_cnt = 0;
  int def_done_cyc = -1;

  rect_copy_controller #(.RECT_COUNT(RC), .RECT_WORDS(RW), .MEM_BASE(BASE_A)) u_dut (
    .clk(clk), .reset_n(reset_n), .copy_start(copy_start), .copy(copy),
    .mem_addr(a_addr), .mem_re(a_re), .mem_rdata(a_rdata),
    .rect_we(a_we), .rect_idx(a_idx), .rect_field(a_fld), .rect_data(a_data),
    .busy(a_busy), .done(a_done), .aborted(a_ab));

  rect_copy_controller #(.RECT_COUNT(RC), .RECT_WORDS(RW), .MEM_BASE(BASE_W)) u_wrap (
    .clk(clk), .reset_n(reset_n), .copy_start(copy_start), .copy(copy),
    .mem_addr(w_addr), .mem_re(w_re), .mem_rdata(w_rdata),
    .rect_we(w_we), .rect_idx(w_idx), .rect_field(w_fld), .rect_data(w_data),
    .busy(w_busy), .done(w_done), .aborted(w_ab));

  rect_copy_controller u_def (
    .clk(clk), .reset_n(reset_n), .copy_start(d_start), .copy(d_copy),
    .mem_addr(d_addr), .mem_re(d_re), .mem_rdata(d_rdata),
    .rect_we(d_we), .rect_idx(d_idx), .rect_field(d_fld), .rect_data(d_data),
    .busy(d_busy), .done(d_done), .aborted(d_ab));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (a_re) a_rdata <= mem[a_addr];
    if (w_re) w_rdata <= mem[w_addr];
    if (d_re) d_rdata <= mem[d_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
  endtask

  // Expected behaviour of one copy whose start is sampled at the edge that
  // makes the cycle counter equal e. cut = 0: full copy; cut = c > 0: the
  // window is closed (or reset applied) during the c-th cycle after the start
  // edge, so only reads k < c-1 and writes k < c-2 are seen.
  task automatic push_exp(input int e, input int cut);
    int nr, nw;
    nr = (cut == 0) ? N : cut - 1;
    nw = (cut == 0) ? N : ((cut >= 2) ? cut - 2 : 0);
    for (int k = 0; k < nr; k++) begin
      q_ra.push_back('{cyc: e + k, addr: 16'(BASE_A + k)});
      q_rw.push_back('{cyc: e + k, addr: 16'(BASE_W + k)});
    end
    for (int k = 0; k < nw; k++) begin
      q_wa.push_back('{cyc: e + 1 + k, idx: 8'(k / RW), fld: 8'(k % RW), data: mem[16'(BASE_A + k)]});
      q_ww.push_back('{cyc: e + 1 + k, idx: 8'(k / RW), fld: 8'(k % RW), data: mem[16'(BASE_W + k)]});
    end
    if (cut == 0) q_done.push_back(e + N + 1);
  endtask

  // Monitor: compares every strobe the DUTs present against the scoreboard.
  always @(negedge clk) begin
    rd_t r;
    wr_t w;
    if (a_re) begin
      if (q_ra.size() == 0) fail_evt("a_read");
      else begin
        r = q_ra.pop_front();
        chk("a_rd_cyc", cyc, r.cyc);
        chk("a_rd_addr", a_addr, r.addr);
      end
    end
    if (a_we) begin
      if (q_wa.size() == 0) fail_evt("a_write");
      else begin
        w = q_wa.pop_front();
        chk("a_wr_cyc", cyc, w.cyc);
        chk("a_wr_idx", a_idx, w.idx);
        chk("a_wr_fld", a_fld, w.fld);
        chk("a_wr_data", a_data, w.data);
      end
    end
    if (a_done) begin
      chk("a_done_busy", a_busy, 1'b0);
      if (q_done.size() == 0) fail_evt("a_done");
      else chk("a_done_cyc", cyc, q_done.pop_front());
    end
    if (w_re) begin
      if (q_rw.size() == 0) fail_evt("w_read");
      else begin
        r = q_rw.pop_front();
        chk("w_rd_cyc", cyc, r.cyc);
        chk("w_rd_addr", w_addr, r.addr);
      end
    end
    if (w_we) begin
      if (q_ww.size() == 0) fail_evt("w_write");
      else begin
        w = q_ww.pop_front();
        chk("w_wr_cyc", cyc, w.cyc);
        chk("w_wr_idx", w_idx, w.idx);
        chk("w_wr_fld", w_fld, w.fld);
        chk("w_wr_data", w_data, w.data);
      end
    end
    if (d_we) begin
      chk("d_wr_idx", d_idx, 32'(def_cnt / 6));
      chk("d_wr_fld", d_fld, 32'(def_cnt % 6));
      chk("d_wr_data", d_data, mem[16'(def_cnt)]);
      def_cnt++;
    end
    if (d_done) def_done_cyc = cyc;
  end

  // One copy on the shared instances. abort_at: window closes in that cycle
  // after the start edge; ign: extra start pulse sampled at that edge;
  // rst_at: reset applied between edges once rst_at reads have been issued.
  task automatic do_copy(input int abort_at, input int ign, input int rst_at);
    int e;
    for (int k = 0; k < N; k++) begin
      mem[16'(BASE_A + k)] = 16'($urandom);
      mem[16'(BASE_W + k)] = 16'($urandom);
    end
    e = cyc + 1;
    push_exp(e, (rst_at != 0) ? rst_at + 1 : abort_at);
    reset_n    = 1'b1;
    copy       = 1'b1;
    copy_start = 1'b1;
    @(posedge clk); #1;
    chk("busy_start", a_busy, 1'b1);
    chk("abort_clear", a_ab, 1'b0);
    for (int c = 1; c <= N + 2; c++) begin
      copy_start = (c == ign);
      if (c == abort_at) copy = 1'b0;
      if (rst_at != 0 && c == rst_at + 1) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy", a_busy, 1'b0);
        chk("rst_mem_re", a_re, 1'b0);
        chk("rst_we", a_we, 1'b0);
        chk("rst_addr", a_addr, 16'h0000);
        copy_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    copy_start = 1'b0;
    if (rst_at == 0) begin
      chk("aborted_end", a_ab, (abort_at != 0) ? 1'b1 : 1'b0);
      chk("busy_end", a_busy, 1'b0);
    end
  endtask

  task automatic idle_start();
    copy       = 1'b0;
    copy_start = 1'b1;
    @(posedge clk); #1;
    copy_start = 1'b0;
    chk("nocopy_busy", a_busy, 1'b0);
    @(posedge clk); #1;
    chk("nocopy_busy2", a_busy, 1'b0);
  endtask

  initial begin
    int kind;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy0", a_busy, 1'b0);
    chk("rst_done0", a_done, 1'b0);
    chk("rst_ab0", a_ab, 1'b0);
    chk("rst_re0", a_re, 1'b0);
    chk("rst_we0", a_we, 1'b0);
    chk("rst_addr0", a_addr, 16'h0000);

    do_copy(0, 0, 0);          // nominal, start on first edge after reset
    do_copy(0, 4, 0);          // ignored start while busy
    do_copy(3, 0, 0);          // abort at t0+3
    do_copy(0, 0, 0);          // restart clears aborted
    idle_start();              // start with copy=0
    do_copy(0, 0, 3);          // async reset mid-READ
    do_copy(0, 0, 0);          // fresh copy from (0,0)
    do_copy(N + 1, 0, 0);      // abort in DRAIN
    do_copy(1, 0, 0);          // abort on first READ edge

    for (int it = 0; it < 24; it++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      kind = $urandom_range(0, 3);
      case (kind)
        0: do_copy($urandom_range(1, N + 1), 0, 0);
        1: do_copy(0, $urandom_range(1, N + 1), 0);
        2: begin idle_start(); do_copy(0, 0, 0); end
        default: do_copy(0, 0, 0);
      endcase
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("q_ra_empty", q_ra.size(), 0);
    chk("q_wa_empty", q_wa.size(), 0);
    chk("q_rw_empty", q_rw.size(), 0);
    chk("q_ww_empty", q_ww.size(), 0);
    chk("q_done_empty", q_done.size(), 0);

    // Default-parameter instance: one full copy
    begin
      int e;
      copy    = 1'b0;
      d_copy  = 1'b1;
      d_start = 1'b1;
      e = cyc + 1;
      @(posedge clk); #1;
      d_start = 1'b0;
      repeat (400) begin @(posedge clk); #1; end
      chk("d_write_count", def_cnt, 384);
      chk("d_done_cyc", def_done_cyc, e + 385);
      chk("d_aborted", d_ab, 1'b0);
      chk("d_busy_end", d_busy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
